// File: rtl/board_display_io.sv
// Board I/O stage: debounced step button with press counter, 32-bit PC/register
// snapshot, and a 4-digit active-low seven-segment hex scanner.
module board_display_io #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int SCAN_CYCLES     = 100000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        step_button,
    input  logic        show_reg,
    input  logic        half_sel,
    input  logic [31:0] pc_out,
    input  logic [31:0] register_out,
    output logic        step_pulse,
    output logic [15:0] step_count,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int SC_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CYCLES - 1);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    logic            sync_meta_q, sync_q;
    logic            stable_q, stable_d, stable_dly_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            pulse_q, pulse_d;
    logic [15:0]     step_cnt_q, step_cnt_d;
    logic            show_reg_q;
    logic [31:0]     snap_q, snap_d;
    logic [SC_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]      digit_q, digit_d;
    logic [3:0]      anode_q, anode_d;
    logic [6:0]      cathode_q, cathode_d;
    logic            dp_q, dp_d;
    logic [15:0]     half;
    logic [3:0]      nibble;

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        if (sync_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = sync_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end

        pulse_d    = stable_q & ~stable_dly_q;
        step_cnt_d = step_cnt_q + {15'd0, pulse_q};

        // Loading one cycle after the pulse lets the pipeline advance first.
        snap_d = snap_q;
        if (pulse_q || (show_reg != show_reg_q))
            snap_d = show_reg ? register_out : pc_out;

        scan_cnt_d = scan_cnt_q + SC_W'(1);
        digit_d    = digit_q;
        if (scan_cnt_q == SC_LAST) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 2'd1;
        end

        half      = half_sel ? snap_q[31:16] : snap_q[15:0];
        nibble    = half[{digit_q, 2'b00} +: 4];
        anode_d   = ~(4'b0001 << digit_q);
        cathode_d = hex7(nibble);
        dp_d      = ~((digit_q == 2'd0) && show_reg);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_meta_q  <= 1'b0;
            sync_q       <= 1'b0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
            db_cnt_q     <= '0;
            pulse_q      <= 1'b0;
            step_cnt_q   <= 16'h0000;
            show_reg_q   <= 1'b0;
            snap_q       <= 32'h0;
            scan_cnt_q   <= '0;
            digit_q      <= 2'd0;
            anode_q      <= 4'b1111;
            cathode_q    <= 7'h7F;
            dp_q         <= 1'b1;
        end else begin
            sync_meta_q  <= step_button;
            sync_q       <= sync_meta_q;
            stable_q     <= stable_d;
            stable_dly_q <= stable_q;
            db_cnt_q     <= db_cnt_d;
            pulse_q      <= pulse_d;
            step_cnt_q   <= step_cnt_d;
            show_reg_q   <= show_reg;
            snap_q       <= snap_d;
            scan_cnt_q   <= scan_cnt_d;
            digit_q      <= digit_d;
            anode_q      <= anode_d;
            cathode_q    <= cathode_d;
            dp_q         <= dp_d;
        end
    end

    assign step_pulse = pulse_q;
    assign step_count = step_cnt_q;
    assign anode      = anode_q;
    assign cathode    = cathode_q;
    assign dp         = dp_q;

endmodule

// File: tb/tb_board_display_io.sv
// Directed bench for board_display_io with DEBOUNCE_CYCLES=4, SCAN_CYCLES=3.
module tb_board_display_io;

    logic        clock = 1'b0;
    logic        reset;
    logic        step_button;
    logic        show_reg;
    logic        half_sel;
    logic [31:0] pc_out;
    logic [31:0] register_out;
    logic        step_pulse;
    logic [15:0] step_count;
    logic [3:0]  anode;
    logic [6:0]  cathode;
    logic        dp;

    int checks = 0;
    int passes = 0;

    board_display_io #(.DEBOUNCE_CYCLES(4), .SCAN_CYCLES(3)) dut (
        .clock(clock), .reset(reset), .step_button(step_button),
        .show_reg(show_reg), .half_sel(half_sel), .pc_out(pc_out),
        .register_out(register_out), .step_pulse(step_pulse),
        .step_count(step_count), .anode(anode), .cathode(cathode), .dp(dp)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        repeat (4) tick();
        reset = 1'b0;
        #1;
        checks++;
        if (anode !== 4'b1111) $display("FAIL reset_anode got %b want 1111", anode); else passes++;
        checks++;
        if (cathode !== 7'h7F) $display("FAIL reset_cathode got %b want 1111111", cathode); else passes++;
        checks++;
        if (dp !== 1'b1 || step_pulse !== 1'b0) $display("FAIL reset_dp_pulse got dp=%b pulse=%b want 1/0", dp, step_pulse); else passes++;
        checks++;
        if (step_count !== 16'h0) $display("FAIL reset_count got %h want 0000", step_count); else passes++;
        #2;
        reset = 1'b1;
        tick();
        checks++;
        if (anode !== 4'b1110 || cathode !== 7'b1000000)
            $display("FAIL reset_release got anode=%b cathode=%b want 1110/1000000", anode, cathode);
        else passes++;
    endtask

    task automatic test_clean_press();
        int pulses = 0;
        int pulse_at = -1;
        logic [6:0] exp_seg [4];
        logic [3:0] seen = 4'b0000;
        int d;
        pc_out = 32'h0000_0040;
        step_button = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (step_pulse === 1'b1) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
        end
        step_button = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (step_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) $display("FAIL press_pulse_count got %0d want 1", pulses); else passes++;
        checks++;
        if (pulse_at != 6) $display("FAIL press_latency got %0d want 6", pulse_at); else passes++;
        checks++;
        if (step_count !== 16'd1) $display("FAIL press_count got %h want 0001", step_count); else passes++;
        exp_seg[0] = 7'b1000000;
        exp_seg[1] = 7'b0011001;
        exp_seg[2] = 7'b1000000;
        exp_seg[3] = 7'b1000000;
        for (int i = 0; i < 12; i++) begin
            tick();
            case (anode)
                4'b1110: d = 0;
                4'b1101: d = 1;
                4'b1011: d = 2;
                4'b0111: d = 3;
                default: d = -1;
            endcase
            checks++;
            if (d < 0) $display("FAIL press_anode_onehot got %b want one low bit", anode);
            else if (cathode !== exp_seg[d]) $display("FAIL press_digit%0d got %b want %b", d, cathode, exp_seg[d]);
            else begin
                passes++;
                seen[d] = 1'b1;
            end
        end
        checks++;
        if (seen !== 4'b1111) $display("FAIL press_digits_seen got %b want 1111", seen); else passes++;
    endtask

    task automatic test_bounce();
        int pulses = 0;
        for (int i = 0; i < 8; i++) begin
            step_button = (i % 2 == 0);
            repeat (2) begin
                tick();
                if (step_pulse === 1'b1) pulses++;
            end
        end
        step_button = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (step_pulse === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) $display("FAIL bounce_pulses got %0d want 0", pulses); else passes++;
        checks++;
        if (step_count !== 16'd1) $display("FAIL bounce_count got %h want 0001", step_count); else passes++;
    endtask

    task automatic test_register_view();
        logic [6:0] exp_seg [4];
        int d;
        register_out = 32'hDEAD_BEEF;
        half_sel = 1'b1;
        show_reg = 1'b1;
        tick();
        pc_out = 32'h1234_5678;
        tick();
        for (int phase = 0; phase < 2; phase++) begin
            if (phase == 0) begin
                exp_seg[0] = 7'b0100001;
                exp_seg[1] = 7'b0001000;
                exp_seg[2] = 7'b0000110;
                exp_seg[3] = 7'b0100001;
            end else begin
                half_sel = 1'b0;
                tick();
                exp_seg[0] = 7'b0001110;
                exp_seg[1] = 7'b0000110;
                exp_seg[2] = 7'b0000110;
                exp_seg[3] = 7'b0000011;
            end
            for (int i = 0; i < 12; i++) begin
                tick();
                case (anode)
                    4'b1110: d = 0;
                    4'b1101: d = 1;
                    4'b1011: d = 2;
                    4'b0111: d = 3;
                    default: d = -1;
                endcase
                checks++;
                if (d < 0) $display("FAIL regview_anode got %b want one low bit", anode);
                else if (cathode !== exp_seg[d])
                    $display("FAIL regview_p%0d_digit%0d got %b want %b", phase, d, cathode, exp_seg[d]);
                else passes++;
                checks++;
                if (dp !== ((d == 0) ? 1'b0 : 1'b1))
                    $display("FAIL regview_dp anode=%b got %b want %b", anode, dp, (d == 0) ? 1'b0 : 1'b1);
                else passes++;
            end
        end
    endtask

    task automatic test_wrap();
        int waited = 0;
        show_reg = 1'b0;
        tick();
        force dut.step_cnt_q = 16'hFFFF;
        #1;
        release dut.step_cnt_q;
        tick();
        tick();
        checks++;
        if (step_count !== 16'hFFFF) $display("FAIL wrap_preload got %h want ffff", step_count); else passes++;
        step_button = 1'b1;
        while (step_pulse !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (step_pulse !== 1'b1) $display("FAIL wrap_pulse_timeout got %b want 1", step_pulse); else passes++;
        tick();
        checks++;
        if (step_count !== 16'h0000) $display("FAIL wrap_count got %h want 0000", step_count); else passes++;
        step_button = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_scan_order();
        logic [3:0] prev;
        logic [3:0] exp_an [4];
        int waited = 0;
        exp_an[0] = 4'b1110;
        exp_an[1] = 4'b1101;
        exp_an[2] = 4'b1011;
        exp_an[3] = 4'b0111;
        prev = anode;
        tick();
        while (!(anode === 4'b1110 && prev !== 4'b1110) && waited < 20) begin
            prev = anode;
            tick();
            waited++;
        end
        checks++;
        if (anode !== 4'b1110) $display("FAIL scan_sync_timeout got %b want 1110", anode); else passes++;
        for (int j = 0; j < 24; j++) begin
            if (j > 0) tick();
            checks++;
            if (anode !== exp_an[(j / 3) % 4])
                $display("FAIL scan_order step %0d got %b want %b", j, anode, exp_an[(j / 3) % 4]);
            else passes++;
        end
    endtask

    initial begin
        reset = 1'b0;
        step_button = 1'b0;
        show_reg = 1'b0;
        half_sel = 1'b0;
        pc_out = 32'h0;
        register_out = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        test_reset();
        test_clean_press();
        test_bounce();
        test_register_view();
        test_wrap();
        test_scan_order();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
